break_monitor8: RTL and testbench
=================================

BREAK_MONITOR8 -- requirements
Module: break_monitor8

Interface
REQ-001 The block SHALL have parameter DW, default 8, giving the watched-bus width.
REQ-002 The block SHALL have parameter CW, default 8, giving the hit-counter width.
REQ-003 The block SHALL have input ck, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have input clr, 1 bit, an asynchronous, active-high reset.
REQ-005 The block SHALL have input data, DW bits, the watched bus (e.g. accumulator reg_out).
REQ-006 The block SHALL have input match_val, DW bits, the compare value.
REQ-007 The block SHALL have input match_mask, DW bits; a 1 selects that bit for comparison.
REQ-008 The block SHALL have input mode, 2 bits: 00 EQ, 01 NE, 10 GT unsigned, 11 LT unsigned.
REQ-009 The block SHALL have input pass_count, CW bits, the hit number that breaks; 0 is treated as 1.
REQ-010 The block SHALL have input arm, 1 bit, a start/restart request.
REQ-011 The block SHALL have input resume, 1 bit, which releases a halt.
REQ-012 The block SHALL have output halt, 1 bit, high while halted.
REQ-013 The block SHALL have output en_n, 1 bit, equal to halt and driving an active-low register EN.
REQ-014 The block SHALL have output hit_count, CW bits, the number of hits since arm.
REQ-015 The block SHALL have output captured, DW bits, the data value at the break.
REQ-016 The block SHALL have output state, 2 bits, the current FSM state.

Function
REQ-017 Condition cond SHALL be computed on (data & match_mask) against (match_val & match_mask) per mode.
REQ-018 A hit SHALL be cond=1 this cycle with prev_cond=1'b0, where prev_cond is cond registered every cycle; a steady matching value counts once.
REQ-019 The FSM SHALL have states IDLE=00, ARMED=01, HALTED=10; code 11 SHALL return to IDLE next edge.
REQ-020 IDLE transitions: arm=1 -> ARMED, hit_count<=0; all other inputs ignored.
REQ-021 ARMED, per hit: hit_count increments, saturating at all-ones.
REQ-022 ARMED break: when the incremented count >= max(pass_count,1), go to HALTED and set captured<=data in that same edge.
REQ-023 ARMED with arm=1: hit_count<=0 and stay ARMED; arm takes priority over a simultaneous hit.
REQ-024 ARMED with resume=1: ignored.
REQ-025 HALTED with resume=1: go to ARMED, hit_count<=0, prev_cond<=1 so the held matching value does not retrigger.
REQ-026 HALTED with arm=1: ignored; resume wins over a simultaneous arm.
REQ-027 Latency: halt SHALL rise on the same clock edge that samples the breaking hit, i.e. registered and one cycle after data settles.
REQ-028 halt SHALL be 1 exactly while state is HALTED.
REQ-029 captured and hit_count SHALL hold their values in HALTED and in IDLE.
REQ-030 pass_count SHALL be sampled continuously; a change while ARMED takes effect on the next hit.

Reset
REQ-031 clr=1 SHALL immediately, without waiting for ck, force state=IDLE, halt=0, en_n=0, hit_count=0, captured=0, prev_cond=0.
REQ-032 Reset mid-operation, including while HALTED, SHALL discard all progress; after release the block waits in IDLE for arm.

Structure
REQ-033 Package break_pkg SHALL hold the state encodings (IDLE, ARMED, HALTED) and the mode encodings (EQ, NE, GT, LT).
REQ-034 Sub-module break_cmp8, combinational, SHALL compute cond from data, match_val, match_mask and mode; the FSM, counter and capture live in break_monitor8.

Verification
REQ-035 Scenario, EQ break: mask=FF, val=42, pass=1; arm, then step data 40,41,42 -> halt=1 at the edge sampling 42; captured=42; hit_count=1; en_n=1.
REQ-036 Scenario, Nth hit: pass=3, EQ, val=05; data toggles 05,00,05,00,05 -> halt only on the third 05; data held at 05 for 4 cycles gives a single hit.
REQ-037 Scenario, masked GT: mask=F0, val=30, GT; data 3F then 40 -> 3F no hit; 40 breaks; captured=40.
REQ-038 Scenario, resume: halted on 42, data stays 42, resume -> ARMED, hit_count=0, no retrigger; data 00 then 42 -> halts again.
REQ-039 Scenario, priority: arm together with a breaking hit in ARMED -> stays ARMED with hit_count=0; arm together with resume in HALTED -> ARMED.
REQ-040 Scenario, async reset: assert clr between edges while HALTED -> halt=0 and state=00 before the next ck edge; a later hit in IDLE has no effect.

Source files
------------

// File: rtl/break_pkg.sv
// Shared encodings for the break monitor: FSM states and compare modes.
package break_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    HALTED = 2'b10,
    RSVD   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    EQ = 2'b00,
    NE = 2'b01,
    GT = 2'b10,
    LT = 2'b11
  } mode_e;

endpackage

// File: rtl/break_cmp8.sv
// Masked comparator: evaluates the break condition on the watched bus.
module break_cmp8
  import break_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic [DW-1:0] data,
  input  logic [DW-1:0] match_val,
  input  logic [DW-1:0] match_mask,
  input  logic [1:0]    mode,
  output logic          cond_c
);

  logic [DW-1:0] lhs;
  logic [DW-1:0] rhs;

  assign lhs = data & match_mask;
  assign rhs = match_val & match_mask;

  // Select the relation; unmasked bits are zero on both sides so they never decide.
  always_comb begin
    cond_c = 1'b0;
    case (mode_e'(mode))
      EQ:      cond_c = (lhs == rhs);
      NE:      cond_c = (lhs != rhs);
      GT:      cond_c = (lhs > rhs);
      LT:      cond_c = (lhs < rhs);
      default: cond_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/break_monitor8.sv
// Breakpoint monitor: counts rising edges of a masked compare and halts on the Nth.
module break_monitor8
  import break_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 8
) (
  input  logic          ck,
  input  logic          clr,
  input  logic [DW-1:0] data,
  input  logic [DW-1:0] match_val,
  input  logic [DW-1:0] match_mask,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] pass_count,
  input  logic          arm,
  input  logic          resume,
  output logic          halt,
  output logic          en_n,
  output logic [CW-1:0] hit_count,
  output logic [DW-1:0] captured,
  output logic [1:0]    state
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] cap_q, cap_d;
  logic          prev_q, prev_d;
  logic          halt_q, halt_d;

  logic          cond_c;
  logic          hit_c;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] pass_eff;

  break_cmp8 #(.DW(DW)) u_cmp (
    .data       (data),
    .match_val  (match_val),
    .match_mask (match_mask),
    .mode       (mode),
    .cond_c     (cond_c)
  );

  // A hit is the first cycle of a matching run, so a held value counts once.
  assign hit_c    = cond_c & ~prev_q;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
  assign pass_eff = (pass_count == '0) ? CW'(1) : pass_count;

  // Next-state, counter and capture decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    prev_d  = cond_c;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          cnt_d   = '0;
        end
      end
      ARMED: begin
        if (arm) begin
          cnt_d = '0;
        end else if (hit_c) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= pass_eff) begin
            state_d = HALTED;
            cap_d   = data;
          end
        end
      end
      HALTED: begin
        if (resume) begin
          state_d = ARMED;
          cnt_d   = '0;
          prev_d  = 1'b1;   // held matching value must not retrigger
        end
      end
      default: state_d = IDLE;
    endcase
    halt_d = (state_d == HALTED);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge ck or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      prev_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      prev_q  <= prev_d;
      halt_q  <= halt_d;
    end
  end

  assign halt      = halt_q;
  assign en_n      = halt_q;
  assign hit_count = cnt_q;
  assign captured  = cap_q;
  assign state     = 2'(state_q);

endmodule

// File: tb/tb_break_monitor8.sv
// Directed bench for break_monitor8 with a rule-level reference model.
module tb_break_monitor8;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  logic          ck = 1'b0;
  logic          clr;
  logic [DW-1:0] data;
  logic [DW-1:0] match_val;
  logic [DW-1:0] match_mask;
  logic [1:0]    mode;
  logic [CW-1:0] pass_count;
  logic          arm;
  logic          resume;
  logic          halt;
  logic          en_n;
  logic [CW-1:0] hit_count;
  logic [DW-1:0] captured;
  logic [1:0]    state;

  int errs   = 0;
  int checks = 0;

  break_monitor8 #(.DW(DW), .CW(CW)) dut (
    .ck         (ck),
    .clr        (clr),
    .data       (data),
    .match_val  (match_val),
    .match_mask (match_mask),
    .mode       (mode),
    .pass_count (pass_count),
    .arm        (arm),
    .resume     (resume),
    .halt       (halt),
    .en_n       (en_n),
    .hit_count  (hit_count),
    .captured   (captured),
    .state      (state)
  );

  always #5 ck = ~ck;

  // Reference model: 0 idle, 1 armed, 2 halted.
  int m_st   = 0;
  int m_cnt  = 0;
  int m_cap  = 0;
  bit m_prev = 0;

  function automatic bit model_cond(int d, int v, int m, int md);
    int a, b;
    a = d & m;
    b = v & m;
    case (md)
      0: return a == b;
      1: return a != b;
      2: return a > b;
      default: return a < b;
    endcase
  endfunction

  always @(posedge ck or posedge clr) begin
    bit c, hit, rel;
    int need;
    if (clr) begin
      m_st = 0; m_cnt = 0; m_cap = 0; m_prev = 0;
    end else begin
      c    = model_cond(int'(data), int'(match_val), int'(match_mask), int'(mode));
      hit  = c && !m_prev;
      rel  = (m_st == 2) && resume;
      need = (pass_count == 0) ? 1 : int'(pass_count);
      if (m_st == 0) begin
        if (arm) begin m_st = 1; m_cnt = 0; end
      end else if (m_st == 1) begin
        if (arm) m_cnt = 0;
        else if (hit) begin
          if (m_cnt < (1 << CW) - 1) m_cnt = m_cnt + 1;
          if (m_cnt >= need) begin m_st = 2; m_cap = int'(data); end
        end
      end else if (resume) begin
        m_st = 1; m_cnt = 0;
      end
      m_prev = rel ? 1'b1 : c;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare of all outputs against the model.
  always @(negedge ck) begin
    if (!clr) begin
      chk("state",     int'(state),     m_st);
      chk("halt",      int'(halt),      (m_st == 2) ? 1 : 0);
      chk("en_n",      int'(en_n),      (m_st == 2) ? 1 : 0);
      chk("hit_count", int'(hit_count), m_cnt);
      chk("captured",  int'(captured),  m_cap);
    end
  end

  task automatic tick();
    @(posedge ck);
    @(negedge ck);
    #1;
  endtask

  task automatic put(input logic [DW-1:0] d);
    data = d;
    tick();
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pulse_resume();
    resume = 1'b1; tick(); resume = 1'b0;
  endtask

  initial begin
    clr = 1'b1; data = '0; match_val = 8'h42; match_mask = 8'hFF;
    mode = 2'b00; pass_count = 8'd1; arm = 1'b0; resume = 1'b0;
    #12;
    chk("rst_state", int'(state), 0);
    chk("rst_halt",  int'(halt), 0);
    clr = 1'b0;
    tick();

    // EQ break on 42.
    pulse_arm();
    chk("armed", int'(state), 1);
    put(8'h40);
    put(8'h41);
    chk("pre42_halt", int'(halt), 0);
    put(8'h42);
    chk("eq_halt", int'(halt), 1);
    chk("eq_en_n", int'(en_n), 1);
    chk("eq_cap",  int'(captured), 8'h42);
    chk("eq_cnt",  int'(hit_count), 1);

    // Resume with 42 held: no retrigger, then re-break after 00,42.
    pulse_resume();
    chk("res_state", int'(state), 1);
    chk("res_cnt",   int'(hit_count), 0);
    put(8'h42);
    chk("res_noretrig", int'(state), 1);
    put(8'h00);
    put(8'h42);
    chk("res_rebreak", int'(state), 2);

    // Arm and resume together in HALTED -> ARMED.
    arm = 1'b1; resume = 1'b1; tick(); arm = 1'b0; resume = 1'b0;
    chk("prio_res_state", int'(state), 1);
    chk("prio_res_cnt",   int'(hit_count), 0);
    put(8'h00);
    // Arm together with a breaking hit -> stays ARMED, count cleared.
    arm = 1'b1; put(8'h42); arm = 1'b0;
    chk("prio_arm_state", int'(state), 1);
    chk("prio_arm_cnt",   int'(hit_count), 0);

    // Nth hit: pass=3, held value counts once.
    match_val = 8'h05; pass_count = 8'd3; data = 8'h00;
    pulse_arm();
    repeat (4) put(8'h05);
    chk("held_cnt", int'(hit_count), 1);
    put(8'h00);
    put(8'h05);
    chk("nth2_state", int'(state), 1);
    put(8'h00);
    put(8'h05);
    chk("nth3_halt", int'(halt), 1);
    chk("nth3_cnt",  int'(hit_count), 3);
    chk("nth3_cap",  int'(captured), 8'h05);

    // Masked GT: 3F masks to 30 (not GT 30), 40 breaks.
    pulse_resume();
    match_mask = 8'hF0; match_val = 8'h30; mode = 2'b10; pass_count = 8'd1;
    put(8'h00);
    pulse_arm();
    put(8'h3F);
    chk("gt_3f", int'(state), 1);
    put(8'h40);
    chk("gt_halt", int'(halt), 1);
    chk("gt_cap",  int'(captured), 8'h40);

    // Async clear between edges while halted.
    #2 clr = 1'b1;
    #1;
    chk("async_halt",  int'(halt), 0);
    chk("async_state", int'(state), 0);
    chk("async_cap",   int'(captured), 0);
    #1 clr = 1'b0;
    put(8'h00);
    put(8'h40);
    chk("idle_ignore", int'(state), 0);

    // pass_count 0 behaves as 1; LT and NE modes.
    mode = 2'b11; match_mask = 8'hFF; match_val = 8'h10; pass_count = 8'd0;
    put(8'h20);
    pulse_arm();
    put(8'h05);
    chk("lt_pass0", int'(halt), 1);
    pulse_resume();
    mode = 2'b01; match_val = 8'h05; pass_count = 8'd2;
    put(8'h05);
    put(8'h06);
    put(8'h05);
    put(8'h07);
    chk("ne_halt", int'(state), 2);
    chk("ne_cap",  int'(captured), 8'h07);

    // pass_count change while armed applies to the next hit.
    pulse_resume();
    put(8'h05);
    pass_count = 8'd1;
    put(8'h09);
    chk("pass_live", int'(state), 2);

    // Illegal state recovery is not reachable from ports; settle and finish.
    tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
